ttc3_id_bank: RTL and testbench
===============================

Name: ttc3_id_bank

Overview:
Multi-slot successor to the single-ID device ID store. After reset it autonomously fetches NUM_SLOTS identity values (device ID, lot ID, key-seed IDs, …) word by word from an external fuse controller over a req/ack handshake. It substitutes per-slot defaults for blank fuses, then freezes all slots until the next reset. Slots are read through a registered indexed read port; per-slot valid flags and load status are exported to the TTC3 security logic.

Parameters:
NUM_SLOTS, 4, number of ID slots (1..16)
ID_WIDTH, 128, bits per slot; must be a multiple of FUSE_WIDTH
FUSE_WIDTH, 32, fuse controller data word width
ACK_TIMEOUT, 64, max cycles fuse_req may wait for fuse_ack before fault
DEFAULT_ID, 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF, base default; slot i default = DEFAULT_ID ^ i (i zero-extended)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
fuse_req  out  1  fuse word read request
fuse_addr  out  8  fuse word address
fuse_ack  in  1  read acknowledge; fuse_rdata valid in the same cycle
fuse_rdata  in  FUSE_WIDTH  fuse word data
rd_en  in  1  read strobe
rd_sel  in  $clog2(NUM_SLOTS)+1  slot index
rd_data  out  ID_WIDTH  registered slot contents
rd_valid  out  1  rd_data qualifier
id_valid  out  NUM_SLOTS  per-slot loaded flag
load_done  out  1  load sequence finished (success or fault)
load_fault  out  1  load aborted by timeout or checksum error

Behaviour:
- Reset (async assert, sync release): all slots and staging = 0; id_valid = 0; load_done = load_fault = fuse_req = rd_valid = 0; rd_data = 0; FSM = IDLE.
- WORDS = ID_WIDTH/FUSE_WIDTH. Slot stride S = WORDS (WORDS+1 with checksum). fuse_addr = slot*S + word.
- FSM:
  - IDLE → REQ one cycle after reset release.
  - REQ: fuse_req = 1, fuse_addr stable. On fuse_ack, capture fuse_rdata into staging bits [w*FUSE_WIDTH +: FUSE_WIDTH] (word 0 = LSBs) and deassert fuse_req the next cycle.
    - Last word of the slot → CHECK.
    - Otherwise → GAP, one idle cycle, then REQ with the next address.
  - CHECK (1 cycle): staging == 0 (blank) → slot = default; else slot = staging. Set id_valid[slot]. Clear staging.
    - Last slot → DONE.
    - Otherwise → GAP, then REQ for the next slot.
  - DONE: load_done = 1, terminal until reset.
  - FAULT: load_done = 1, load_fault = 1, terminal; already-loaded slots are kept, the rest stay 0 with id_valid = 0.
- Timeout: a counter runs while fuse_req = 1. If it reaches ACK_TIMEOUT without an ack, go to FAULT and drop fuse_req. An ack arriving on the same cycle as the timeout wins.
- fuse_ack while fuse_req = 0 is ignored.
- Immutability: slot registers are written only in CHECK. There is no path back to IDLE except reset.
- Read port: 1-cycle latency. rd_valid(t+1) = rd_en(t). rd_data = slot[rd_sel] if rd_sel < NUM_SLOTS and id_valid[rd_sel], else 0. rd_data holds its value when rd_en = 0. Reads are legal in any state.
- Reset mid-load: the load is aborted, everything clears, and the full sequence restarts from slot 0 after release.

Optional Feature:
ID_CHECKSUM_EN: each slot has one extra fuse word at offset WORDS, which must equal the XOR of the slot's WORDS data words.
- Fetched as a normal REQ/ack word.
- In CHECK, a mismatch → FAULT.
- The blank rule applies only if data words and checksum are all zero.
- Without the macro: S = WORDS, no checksum fetch, no checksum fault source.

Decomposition:
- Package ttc3_id_pkg holds:
  - state enum (IDLE, REQ, GAP, CHECK, DONE, FAULT)
  - FUSE_ADDR_W = 8
  - function computing slot default from DEFAULT_ID and index
- Sub-module ttc3_fuse_reader handles the req/ack handshake, address hold and timeout counter. It returns word_valid, word_data and timeout to the sequencing FSM.

Test Plan:
- Fuse model: 1-cycle ack, slots filled 128'h1111…, 128'h2222…, 128'h3333…, 128'h4444… → load_done = 1, load_fault = 0, id_valid = 4'hF; rd_sel = 2 returns 128'h3333… one cycle later.
- Slot 1 fuses all zero → slot 1 reads 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEE; id_valid = 4'hF.
- Ack withheld on slot 2 word 0 → fuse_req drops after 64 cycles, load_fault = 1, id_valid = 4'b0011, rd_sel = 2 returns 0.
- After DONE, drive spurious fuse_ack with 32'hFFFFFFFF for 20 cycles → all slots unchanged; rd_sel = 5 → rd_data = 0 with rd_valid = 1.
- reset_n pulsed low mid-slot 1 → outputs 0 immediately, fuse_addr restarts at 0, reload completes with the new fuse contents.
- ID_CHECKSUM_EN defined, slot 0 checksum word wrong by one bit → FAULT after slot 0 CHECK, id_valid = 0, load_fault = 1.

Source files
------------

// File: rtl/ttc3_id_bank_pkg.sv
// ttc3_id_pkg: shared types and helpers for the TTC3 ID bank.
// Holds the load-sequencer state encoding, the fuse address width and
// the per-slot default-ID derivation.
package ttc3_id_pkg;

  localparam int FUSE_ADDR_W = 8;
  // Widest ID the default helper can produce; callers truncate to ID_WIDTH.
  localparam int ID_MAX_W = 512;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_GAP   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } ttc3_id_state_e;

  // Default for slot idx: base ID with the slot index XORed into the LSBs.
  function automatic logic [ID_MAX_W-1:0] slot_default(
    input logic [ID_MAX_W-1:0] base,
    input int unsigned         idx
  );
    return base ^ ID_MAX_W'(idx);
  endfunction

endpackage

// File: rtl/ttc3_id_bank_if.sv
// ttc3_id_bank_if: req/ack read bus between the ID bank and the fuse controller.
// master = ID bank (issues requests), slave = fuse controller.
interface ttc3_id_bank_if #(
  parameter int FUSE_WIDTH = 32
);
  import ttc3_id_pkg::*;

  logic                   fuse_req;
  logic [FUSE_ADDR_W-1:0] fuse_addr;
  logic                   fuse_ack;
  logic [FUSE_WIDTH-1:0]  fuse_rdata;

  modport master (
    output fuse_req,
    output fuse_addr,
    input  fuse_ack,
    input  fuse_rdata
  );

  modport slave (
    input  fuse_req,
    input  fuse_addr,
    output fuse_ack,
    output fuse_rdata
  );

endinterface

// File: rtl/ttc3_id_bank_fuse_reader.sv
// ttc3_fuse_reader: single-word fuse read engine.
// An issue pulse latches the address and raises fuse_req; the request drops
// the cycle after an ack or after ACK_TIMEOUT request cycles without one.
// An ack on the timeout cycle counts as a successful read.
module ttc3_fuse_reader
  import ttc3_id_pkg::*;
#(
  parameter int FUSE_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  ttc3_id_bank_if.master         fuse,
  input  logic                   issue,
  input  logic [FUSE_ADDR_W-1:0] addr,
  output logic                   word_valid,
  output logic [FUSE_WIDTH-1:0]  word_data,
  output logic                   timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic                   req_r;
  logic [FUSE_ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   timeout_s;

  assign fuse.fuse_req  = req_r;
  assign fuse.fuse_addr = addr_r;

  // Acks outside an outstanding request are ignored.
  assign word_valid = req_r & fuse.fuse_ack;
  assign word_data  = fuse.fuse_rdata;
  assign timeout_s  = req_r & ~fuse.fuse_ack & (cnt_r == CNT_W'(ACK_TIMEOUT - 1));
  assign timeout    = timeout_s;

  // Request flag, held address and wait counter for the outstanding word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_r  <= 1'b0;
      addr_r <= '0;
      cnt_r  <= '0;
    end else if (issue) begin
      req_r  <= 1'b1;
      addr_r <= addr;
      cnt_r  <= '0;
    end else if (req_r && (fuse.fuse_ack || timeout_s)) begin
      req_r  <= 1'b0;
      cnt_r  <= '0;
    end else if (req_r) begin
      cnt_r  <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r  <= cnt_r;
    end
  end

endmodule

// File: rtl/ttc3_id_bank.sv
// ttc3_id_bank: multi-slot identity store loaded once from fuses after reset.
// Fetches NUM_SLOTS IDs word by word, substitutes per-slot defaults for blank
// fuses, then freezes until reset. Slots are read through a registered port.
// Optional build macro: ID_CHECKSUM_EN adds one XOR checksum word per slot;
// a mismatch aborts the load with load_fault.
module ttc3_id_bank
  import ttc3_id_pkg::*;
#(
  parameter int                  NUM_SLOTS   = 4,
  parameter int                  ID_WIDTH    = 128,
  parameter int                  FUSE_WIDTH  = 32,
  parameter int                  ACK_TIMEOUT = 64,
  parameter logic [ID_WIDTH-1:0] DEFAULT_ID  = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF
) (
  input  logic                         clock,
  input  logic                         reset_n,
  ttc3_id_bank_if.master               fuse,
  input  logic                         rd_en,
  input  logic [$clog2(NUM_SLOTS):0]   rd_sel,
  output logic [ID_WIDTH-1:0]          rd_data,
  output logic                         rd_valid,
  output logic [NUM_SLOTS-1:0]         id_valid,
  output logic                         load_done,
  output logic                         load_fault
);

  localparam int WORDS = ID_WIDTH / FUSE_WIDTH;
`ifdef ID_CHECKSUM_EN
  localparam int STRIDE = WORDS + 1;
`else
  localparam int STRIDE = WORDS;
`endif
  localparam int WIDX_W = $clog2(STRIDE + 1);
  localparam int SIDX_W = $clog2(NUM_SLOTS + 1);
  localparam int SEL_W  = $clog2(NUM_SLOTS) + 1;
  localparam logic [FUSE_ADDR_W-1:0] STRIDE_A = FUSE_ADDR_W'(STRIDE);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_REQ   = ST_REQ;
  localparam logic [2:0] S_GAP   = ST_GAP;
  localparam logic [2:0] S_CHECK = ST_CHECK;
  localparam logic [2:0] S_DONE  = ST_DONE;
  localparam logic [2:0] S_FAULT = ST_FAULT;

  logic [2:0]             state_r;
  logic [SIDX_W-1:0]      slot_idx_r;
  logic [WIDX_W-1:0]      word_idx_r;
  logic [ID_WIDTH-1:0]    staging_r;
  logic [ID_WIDTH-1:0]    slot_r [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   id_valid_r;
  logic                   load_done_r;
  logic                   load_fault_r;
  logic [ID_WIDTH-1:0]    rd_data_r;
  logic                   rd_valid_r;
`ifdef ID_CHECKSUM_EN
  logic [FUSE_WIDTH-1:0]  csum_r;
`endif

  logic                   issue_s;
  logic [FUSE_ADDR_W-1:0] addr_s;
  logic                   word_valid_s;
  logic [FUSE_WIDTH-1:0]  word_data_s;
  logic                   timeout_s;
  logic                   last_word_s;
  logic                   last_slot_s;
  logic                   blank_s;
  logic                   commit_s;
  logic [ID_WIDTH-1:0]    default_s;
  logic [ID_WIDTH-1:0]    check_value_s;
  logic [ID_WIDTH-1:0]    rd_next_s;

`ifdef ID_CHECKSUM_EN
  // XOR of all data words of a staged ID.
  function automatic logic [FUSE_WIDTH-1:0] xor_fold(input logic [ID_WIDTH-1:0] v);
    logic [FUSE_WIDTH-1:0] acc;
    acc = '0;
    for (int w = 0; w < WORDS; w++) begin
      acc = acc ^ v[w*FUSE_WIDTH +: FUSE_WIDTH];
    end
    return acc;
  endfunction
`endif

  assign rd_data    = rd_data_r;
  assign rd_valid   = rd_valid_r;
  assign id_valid   = id_valid_r;
  assign load_done  = load_done_r;
  assign load_fault = load_fault_r;

  // A new fuse read starts on leaving IDLE and on every GAP cycle.
  assign issue_s     = (state_r == S_IDLE) || (state_r == S_GAP);
  assign addr_s      = FUSE_ADDR_W'(slot_idx_r) * STRIDE_A + FUSE_ADDR_W'(word_idx_r);
  assign last_word_s = (word_idx_r == WIDX_W'(STRIDE - 1));
  assign last_slot_s = (slot_idx_r == SIDX_W'(NUM_SLOTS - 1));

  ttc3_fuse_reader #(
    .FUSE_WIDTH  (FUSE_WIDTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_reader (
    .clock      (clock),
    .reset_n    (reset_n),
    .fuse       (fuse),
    .issue      (issue_s),
    .addr       (addr_s),
    .word_valid (word_valid_s),
    .word_data  (word_data_s),
    .timeout    (timeout_s)
  );

  // Slot value decision: default for blank fuses, checksum gate when enabled.
  always_comb begin
    default_s = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      default_s = (slot_idx_r == SIDX_W'(i))
                ? ID_WIDTH'(slot_default(ID_MAX_W'(DEFAULT_ID), i))
                : default_s;
    end
`ifdef ID_CHECKSUM_EN
    blank_s  = (staging_r == '0) && (csum_r == '0);
    commit_s = (xor_fold(staging_r) == csum_r);
`else
    blank_s  = (staging_r == '0);
    commit_s = 1'b1;
`endif
    if (blank_s) begin
      check_value_s = default_s;
    end else begin
      check_value_s = staging_r;
    end
  end

  // Read mux: only loaded, in-range slots are visible; everything else reads 0.
  always_comb begin
    rd_next_s = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      rd_next_s = ((rd_sel == SEL_W'(i)) && id_valid_r[i]) ? slot_r[i] : rd_next_s;
    end
  end

  // Load sequencer: fetch words, decide each slot, then park in DONE or FAULT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      slot_idx_r   <= '0;
      word_idx_r   <= '0;
      staging_r    <= '0;
      id_valid_r   <= '0;
      load_done_r  <= 1'b0;
      load_fault_r <= 1'b0;
`ifdef ID_CHECKSUM_EN
      csum_r       <= '0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_REQ;
        end
        S_REQ: begin
          if (word_valid_s) begin
            for (int w = 0; w < WORDS; w++) begin
              if (word_idx_r == WIDX_W'(w)) begin
                staging_r[w*FUSE_WIDTH +: FUSE_WIDTH] <= word_data_s;
              end
            end
`ifdef ID_CHECKSUM_EN
            if (word_idx_r == WIDX_W'(WORDS)) begin
              csum_r <= word_data_s;
            end
`endif
            if (last_word_s) begin
              state_r <= S_CHECK;
            end else begin
              word_idx_r <= word_idx_r + WIDX_W'(1);
              state_r    <= S_GAP;
            end
          end else if (timeout_s) begin
            state_r      <= S_FAULT;
            load_done_r  <= 1'b1;
            load_fault_r <= 1'b1;
          end
        end
        S_GAP: begin
          state_r <= S_REQ;
        end
        S_CHECK: begin
          if (!commit_s) begin
            state_r      <= S_FAULT;
            load_done_r  <= 1'b1;
            load_fault_r <= 1'b1;
          end else begin
            id_valid_r <= id_valid_r | (NUM_SLOTS'(1) << slot_idx_r);
            staging_r  <= '0;
`ifdef ID_CHECKSUM_EN
            csum_r     <= '0;
`endif
            word_idx_r <= '0;
            if (last_slot_s) begin
              state_r     <= S_DONE;
              load_done_r <= 1'b1;
            end else begin
              slot_idx_r <= slot_idx_r + SIDX_W'(1);
              state_r    <= S_GAP;
            end
          end
        end
        S_DONE: begin
          state_r <= S_DONE;
        end
        S_FAULT: begin
          state_r <= S_FAULT;
        end
        default: begin
          state_r      <= S_FAULT;
          load_done_r  <= 1'b1;
          load_fault_r <= 1'b1;
        end
      endcase
    end
  end

  // Slot storage: written only on a successful CHECK, otherwise frozen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if ((state_r == S_CHECK) && commit_s && (slot_idx_r == SIDX_W'(i))) begin
          slot_r[i] <= check_value_s;
        end
      end
    end
  end

  // Registered read port; data holds between strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= rd_next_s;
      end
    end
  end

endmodule

// File: tb/tb_ttc3_id_bank.sv
// tb_ttc3_id_bank: directed self-checking bench for ttc3_id_bank.
// Includes a fuse-controller model with normal, withhold and spurious-ack modes.
// With ID_CHECKSUM_EN defined, the checksum-fault scenario is also exercised.
module tb_ttc3_id_bank;

  localparam int WORDS = 4;
`ifdef ID_CHECKSUM_EN
  localparam int STRIDE = 5;
`else
  localparam int STRIDE = 4;
`endif

  localparam logic [127:0] P1   = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] P2   = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] P3   = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] P4   = 128'h44444444_44444444_44444444_44444444;
  localparam logic [127:0] Q1   = 128'h55555555_55555555_55555555_55555555;
  localparam logic [127:0] Q4   = 128'h88888888_88888888_88888888_88888888;
  localparam logic [127:0] DEF1 = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEE;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         rd_en = 1'b0;
  logic [2:0]   rd_sel = 3'd0;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic [3:0]   id_valid;
  logic         load_done;
  logic         load_fault;

  int           errors = 0;
  int           checks = 0;
  int           mode = 0;        // 0 normal, 1 withhold hold_addr, 2 spurious ack
  logic [7:0]   hold_addr = 8'd0;
  logic [31:0]  fuse_mem [256];

  ttc3_id_bank_if #(.FUSE_WIDTH(32)) fuse_bus ();

  ttc3_id_bank dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fuse       (fuse_bus),
    .rd_en      (rd_en),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .id_valid   (id_valid),
    .load_done  (load_done),
    .load_fault (load_fault)
  );

  always #5 clock = ~clock;

  // Fuse controller model: answers at the negedge so ack lands with the request.
  initial begin
    fuse_bus.fuse_ack   = 1'b0;
    fuse_bus.fuse_rdata = 32'd0;
    forever begin
      @(negedge clock);
      if (mode == 2) begin
        fuse_bus.fuse_ack   = 1'b1;
        fuse_bus.fuse_rdata = 32'hFFFFFFFF;
      end else if (fuse_bus.fuse_req && !(mode == 1 && fuse_bus.fuse_addr == hold_addr)) begin
        fuse_bus.fuse_ack   = 1'b1;
        fuse_bus.fuse_rdata = fuse_mem[fuse_bus.fuse_addr];
      end else begin
        fuse_bus.fuse_ack   = 1'b0;
        fuse_bus.fuse_rdata = 32'd0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) fuse_mem[a] = 32'd0;
  endtask

  task automatic fill_slot(input int s, input logic [127:0] v);
    logic [31:0] cs;
    cs = 32'd0;
    for (int w = 0; w < WORDS; w++) begin
      fuse_mem[s*STRIDE + w] = v[w*32 +: 32];
      cs = cs ^ v[w*32 +: 32];
    end
`ifdef ID_CHECKSUM_EN
    fuse_mem[s*STRIDE + WORDS] = cs;
`endif
  endtask

  task automatic fill_std();
    clear_mem();
    fill_slot(0, P1);
    fill_slot(1, P2);
    fill_slot(2, P3);
    fill_slot(3, P4);
  endtask

  task automatic reset_cycle();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clock);
      if (load_done) seen = 1'b1;
    end
    check_val(tag, 128'(seen), 128'd1);
  endtask

  task automatic do_read(input logic [2:0] sel, output logic [127:0] d, output logic v);
    @(negedge clock);
    rd_en  = 1'b1;
    rd_sel = sel;
    @(negedge clock);
    rd_en  = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  initial begin
    logic [127:0] d;
    logic         v;
    int           n;
    bit           hit;

    // Reset state
    fill_std();
    repeat (2) @(negedge clock);
    check_val("rst_done",  128'(load_done), 128'd0);
    check_val("rst_fault", 128'(load_fault), 128'd0);
    check_val("rst_req",   128'(fuse_bus.fuse_req), 128'd0);
    check_val("rst_idv",   128'(id_valid), 128'd0);
    check_val("rst_rdv",   128'(rd_valid), 128'd0);
    check_val("rst_rdd",   rd_data, 128'd0);

    // Normal load of four patterned slots
    @(negedge clock);
    reset_n = 1'b1;
    wait_done("a_done");
    check_val("a_fault", 128'(load_fault), 128'd0);
    check_val("a_idv",   128'(id_valid), 128'hF);
    do_read(3'd2, d, v);
    check_val("a_rd2",   d, P3);
    check_val("a_rdv2",  128'(v), 128'd1);
    do_read(3'd0, d, v);
    check_val("a_rd0",   d, P1);

    // Spurious acks after DONE must not disturb the frozen slots
    @(negedge clock);
    mode = 2;
    repeat (20) @(negedge clock);
    mode = 0;
    repeat (2) @(negedge clock);
    do_read(3'd0, d, v);
    check_val("s_rd0", d, P1);
    do_read(3'd1, d, v);
    check_val("s_rd1", d, P2);
    do_read(3'd2, d, v);
    check_val("s_rd2", d, P3);
    do_read(3'd3, d, v);
    check_val("s_rd3", d, P4);
    @(negedge clock);
    check_val("s_hold",  rd_data, P4);
    check_val("s_rdv0",  128'(rd_valid), 128'd0);
    do_read(3'd5, d, v);
    check_val("s_rd5",   d, 128'd0);
    check_val("s_rdv5",  128'(v), 128'd1);
    check_val("s_idv",   128'(id_valid), 128'hF);

    // Blank slot 1 picks up its default
    fill_std();
    fill_slot(1, 128'd0);
    reset_cycle();
    wait_done("b_done");
    check_val("b_idv",   128'(id_valid), 128'hF);
    do_read(3'd1, d, v);
    check_val("b_rd1",   d, DEF1);
    do_read(3'd3, d, v);
    check_val("b_rd3",   d, P4);

    // Ack withheld on slot 2 word 0 -> timeout fault
    fill_std();
    hold_addr = 8'(2 * STRIDE);
    mode = 1;
    reset_cycle();
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clock);
      if (fuse_bus.fuse_req && fuse_bus.fuse_addr == hold_addr) hit = 1'b1;
    end
    check_val("c_reach", 128'(hit), 128'd1);
    n = 1;
    for (int i = 0; i < 200 && fuse_bus.fuse_req; i++) begin
      @(negedge clock);
      if (fuse_bus.fuse_req) n++;
    end
    check_val("c_reqlen", 128'(n), 128'd64);
    mode = 0;
    @(negedge clock);
    check_val("c_done",  128'(load_done), 128'd1);
    check_val("c_fault", 128'(load_fault), 128'd1);
    check_val("c_idv",   128'(id_valid), 128'h3);
    do_read(3'd2, d, v);
    check_val("c_rd2",   d, 128'd0);
    do_read(3'd1, d, v);
    check_val("c_rd1",   d, P2);

    // Reset in the middle of slot 1, reload with new contents
    fill_std();
    reset_cycle();
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clock);
      if (fuse_bus.fuse_req && fuse_bus.fuse_addr == 8'(STRIDE)) hit = 1'b1;
    end
    check_val("e_reach", 128'(hit), 128'd1);
    check_val("e_pre",   128'(id_valid), 128'h1);
    fill_slot(0, Q1);
    fill_slot(3, Q4);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("e_idv0",  128'(id_valid), 128'd0);
    check_val("e_req0",  128'(fuse_bus.fuse_req), 128'd0);
    check_val("e_done0", 128'(load_done), 128'd0);
    @(negedge clock);
    reset_n = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clock);
      if (fuse_bus.fuse_req) hit = 1'b1;
    end
    check_val("e_reqseen", 128'(hit), 128'd1);
    check_val("e_addr0",   128'(fuse_bus.fuse_addr), 128'd0);
    wait_done("e_done");
    check_val("e_fault", 128'(load_fault), 128'd0);
    do_read(3'd0, d, v);
    check_val("e_rd0",   d, Q1);
    do_read(3'd3, d, v);
    check_val("e_rd3",   d, Q4);

`ifdef ID_CHECKSUM_EN
    // Slot 0 checksum off by one bit -> fault right after slot 0
    fill_std();
    fuse_mem[WORDS] = fuse_mem[WORDS] ^ 32'h00000001;
    reset_cycle();
    wait_done("k_done");
    check_val("k_fault", 128'(load_fault), 128'd1);
    check_val("k_idv",   128'(id_valid), 128'd0);
    do_read(3'd0, d, v);
    check_val("k_rd0",   d, 128'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
